// File: rtl/clk_ratio_meter.sv
// Measures the period and high-phase width of an asynchronous divided clock in
// i_ref_clk cycles, and reports lock once the period has been stable long enough.
module clk_ratio_meter #(
  parameter int CLK_DIV_WIDTH = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_COUNT    = 3
) (
  input  logic                     i_ref_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_div_clk,
  output logic [CLK_DIV_WIDTH-1:0] o_ratio,
  output logic [CLK_DIV_WIDTH-1:0] o_high_cycles,
  output logic                     o_ratio_valid,
  output logic                     o_locked,
  output logic                     o_timeout
);

  localparam int W = CLK_DIV_WIDTH;
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  // pcnt reaching all-ones on the coming edge is the timeout point
  localparam logic [W-1:0] CNT_TRIG = {{(W-1){1'b1}}, 1'b0};
  localparam logic [4:0]   LOCK_C   = 5'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [W-1:0]           pcnt_q, pcnt_d;
  logic [W-1:0]           hcnt_q, hcnt_d;
  logic [W-1:0]           ratio_q, ratio_d;
  logic [W-1:0]           high_q, high_d;
  logic [3:0]             match_q, match_d;
  logic                   seen_q, seen_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;

  logic                   s_s;
  logic                   rise_s;
  logic                   timeout_s;
  logic [W-1:0]           ratio_new_s;
  logic [4:0]             match_inc_s;

  assign s_s         = sync_q[SYNC_STAGES-1];
  assign rise_s      = s_s & ~prev_q;
  assign timeout_s   = i_en && (state_q != IDLE) && !rise_s && (pcnt_q == CNT_TRIG);
  assign ratio_new_s = pcnt_q + CNT_ONE;
  assign match_inc_s = {1'b0, match_q} + 5'd1;

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      sync_q    <= {SYNC_STAGES{1'b0}};
      prev_q    <= 1'b0;
      pcnt_q    <= CNT_ZERO;
      hcnt_q    <= CNT_ZERO;
      ratio_q   <= CNT_ZERO;
      high_q    <= CNT_ZERO;
      match_q   <= 4'd0;
      seen_q    <= 1'b0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      ratio_q   <= ratio_d;
      high_q    <= high_d;
      match_q   <= match_d;
      seen_q    <= seen_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_en) state_d = WAIT_FIRST;
        else      state_d = IDLE;
      end
      WAIT_FIRST: begin
        if (!i_en)       state_d = IDLE;
        else if (rise_s) state_d = MEASURE;
        else             state_d = WAIT_FIRST;
      end
      MEASURE: begin
        if (!i_en)          state_d = IDLE;
        else if (timeout_s) state_d = WAIT_FIRST;
        else                state_d = MEASURE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (SYNC_STAGES > 1) sync_d = {sync_q[SYNC_STAGES-2:0], i_div_clk};
    else                 sync_d = {SYNC_STAGES{i_div_clk}};
    prev_d    = s_s;
    pcnt_d    = pcnt_q;
    hcnt_d    = hcnt_q;
    ratio_d   = ratio_q;
    high_d    = high_q;
    match_d   = match_q;
    seen_d    = seen_q;
    locked_d  = locked_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    if (!i_en || state_q == IDLE) begin
      pcnt_d   = CNT_ZERO;
      hcnt_d   = CNT_ZERO;
      ratio_d  = CNT_ZERO;
      high_d   = CNT_ZERO;
      match_d  = 4'd0;
      seen_d   = 1'b0;
      locked_d = 1'b0;
    end else if (rise_s) begin
      pcnt_d = CNT_ZERO;
      hcnt_d = CNT_ONE;
      if (state_q == MEASURE) begin
        ratio_d = ratio_new_s;
        high_d  = hcnt_q;
        valid_d = 1'b1;
        seen_d  = 1'b1;
        // Only a period with a measured predecessor can extend the match run
        if (seen_q && (ratio_new_s == ratio_q)) begin
          match_d  = (match_inc_s > LOCK_C) ? LOCK_C[3:0] : match_inc_s[3:0];
          locked_d = (match_inc_s >= LOCK_C);
        end else begin
          match_d  = 4'd0;
          locked_d = 1'b0;
        end
      end else begin
        seen_d  = 1'b0;
        match_d = 4'd0;
      end
    end else if (timeout_s) begin
      timeout_d = 1'b1;
      pcnt_d    = CNT_ZERO;
      hcnt_d    = CNT_ZERO;
      ratio_d   = CNT_ZERO;
      high_d    = CNT_ZERO;
      match_d   = 4'd0;
      seen_d    = 1'b0;
      locked_d  = 1'b0;
    end else begin
      pcnt_d = pcnt_q + CNT_ONE;
      if (s_s && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_ONE;
      else                            hcnt_d = hcnt_q;
    end
  end

  assign o_ratio       = ratio_q;
  assign o_high_cycles = high_q;
  assign o_ratio_valid = valid_q;
  assign o_locked      = locked_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench for clk_ratio_meter: directed divided-clock waveforms push
// expected measurements; a negedge monitor pops and checks each output pulse.
module tb_clk_ratio_meter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         div = 1'b0;
  logic [W-1:0] ratio;
  logic [W-1:0] high;
  logic         valid;
  logic         locked;
  logic         tmo;

  clk_ratio_meter #(
    .CLK_DIV_WIDTH(W),
    .SYNC_STAGES  (2),
    .LOCK_COUNT   (3)
  ) dut (
    .i_ref_clk    (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_div_clk    (div),
    .o_ratio      (ratio),
    .o_high_cycles(high),
    .o_ratio_valid(valid),
    .o_locked     (locked),
    .o_timeout    (tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int h;
    int lk;
    int gap;
  } exp_t;

  exp_t vq[$];
  int   tq[$];
  exp_t ev;
  int   tg;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid/timeout pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (vq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: pulse with ratio %0d at cycle %0d, none expected", ratio, cyc);
      end else begin
        ev = vq.pop_front();
        check("ratio", 32'(ratio), ev.r);
        check("high_cycles", 32'(high), ev.h);
        check("locked", 32'(locked), ev.lk);
        if (ev.gap > 0) check("valid_gap", cyc - last_valid, ev.gap);
      end
      last_valid = cyc;
    end
    if (tmo === 1'b1) begin
      if (tq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_timeout: pulse at cycle %0d, none expected", cyc);
      end else begin
        tg = tq.pop_front();
        check("timeout_gap", cyc - last_valid, tg);
        check("timeout_ratio", 32'(ratio), 0);
        check("timeout_high", 32'(high), 0);
        check("timeout_locked", 32'(locked), 0);
      end
    end
  end

  task automatic idle_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // One divided-clock period; its opening rise closes the previous period
  task automatic step(int h, int l, int e, int r, int hc, int lk, int gap);
    if (e != 0) vq.push_back('{r, hc, lk, gap});
    div = 1'b1;
    repeat (h) @(negedge clk);
    div = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ratio"}, 32'(ratio), 0);
    check({tag, "_high"}, 32'(high), 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_timeout"}, 32'(tmo), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      div = ~div;
      @(negedge clk);
    end
    check_all_zero("reset");

    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      div = ~div;
      @(negedge clk);
    end
    check_all_zero("idle");
    div = 1'b0;
    idle_cycles(3);

    // Ratio 4, lock on the 5th rise
    en = 1'b1;
    idle_cycles(2);
    step(2, 2, 0, 0, 0, 0, 0);
    step(2, 2, 1, 4, 2, 0, 0);
    step(2, 2, 1, 4, 2, 0, 4);
    step(2, 2, 1, 4, 2, 0, 4);
    step(2, 2, 1, 4, 2, 1, 4);
    step(2, 2, 1, 4, 2, 1, 4);

    // Ratio change 4 -> 6 while locked
    step(3, 3, 1, 4, 2, 1, 4);
    step(3, 3, 1, 6, 3, 0, 6);
    step(3, 3, 1, 6, 3, 0, 6);
    step(3, 3, 1, 6, 3, 0, 6);
    step(3, 3, 1, 6, 3, 1, 6);

    // Clock stops: one timeout 255 cycles after the last valid
    tq.push_back(255);
    div = 1'b0;
    idle_cycles(290);
    check("after_timeout_ratio", 32'(ratio), 0);
    check("after_timeout_locked", 32'(locked), 0);

    // Restart at ratio 4, then odd ratio 5 (2 high / 3 low)
    step(2, 2, 0, 0, 0, 0, 0);
    step(2, 2, 1, 4, 2, 0, 0);
    step(2, 3, 1, 4, 2, 0, 4);
    step(2, 3, 1, 5, 2, 0, 5);
    step(2, 3, 1, 5, 2, 0, 5);
    step(2, 3, 1, 5, 2, 0, 5);
    step(2, 3, 1, 5, 2, 1, 5);
    check("pre_reset_locked", 32'(locked), 1);
    check("pre_reset_ratio", 32'(ratio), 5);

    // Disable and reset mid-period: outputs clear with no pulses
    div = 1'b1;
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    div = 1'b0;
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(2);
    en = 1'b1;
    idle_cycles(2);

    // Ratio 3 (1 high / 2 low) after re-enable
    step(1, 2, 0, 0, 0, 0, 0);
    step(1, 2, 1, 3, 1, 0, 0);
    step(1, 2, 1, 3, 1, 0, 3);
    step(1, 2, 1, 3, 1, 0, 3);
    step(1, 2, 1, 3, 1, 1, 3);
    idle_cycles(10);

    check("valid_queue_empty", vq.size(), 0);
    check("timeout_queue_empty", tq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
